// File: rtl/encoder_8b10b_multi.sv
// Multi-byte 8b/10b encoder with one running disparity chained across the bytes of a beat
// and carried between beats; single registered stage with valid/ready on both sides.
module encoder_8b10b_multi #(
  parameter int unsigned NUM_BYTES   = 2,
  parameter bit          INIT_RD_POS = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [8*NUM_BYTES-1:0]  data_i,
  input  logic [NUM_BYTES-1:0]    is_k_i,
  input  logic                    rd_clr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [10*NUM_BYTES-1:0] encoded_o,
  output logic [NUM_BYTES-1:0]    kerr_o,
  output logic                    rd_pos_o
);

  // 5b/6b codes {a..e,i} as seen from RD-
  function automatic logic [5:0] d6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b codes {f,g,h,j} as seen from RD-, data and control columns
  function automatic logic [3:0] d4_neg(input logic [2:0] y, input logic k);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = k ? 4'b0110 : 4'b1001;
      3'd2:    c = k ? 4'b1010 : 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = k ? 4'b0101 : 4'b1010;
      3'd6:    c = k ? 4'b1001 : 4'b0110;
      default: c = k ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // Returns {kerr, rd_out, abcdei, fghj}; illegal K requests fall back to K28.5
  function automatic logic [11:0] enc_byte(input logic [7:0] d, input logic k, input logic rd);
    logic       bad, u6, u4, rd6, rd4, alt, flip4;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    bad = k && !((d[4:0] == 5'd28) ||
                 ((d[7:5] == 3'd7) && (d[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30})));
    x   = bad ? 5'd28 : d[4:0];
    y   = bad ? 3'd5  : d[7:5];
    c6  = (k && (x == 5'd28)) ? 6'b001111 : d6_neg(x);
    u6  = (3'(c6[0]) + 3'(c6[1]) + 3'(c6[2]) + 3'(c6[3]) + 3'(c6[4]) + 3'(c6[5])) != 3'd3;
    if (rd && (u6 || (!k && (x == 5'd7)))) c6 = ~c6;
    rd6 = rd ^ u6;
    alt = !k && (y == 3'd7) &&
          ((!rd6 && (x inside {5'd17, 5'd18, 5'd20})) || (rd6 && (x inside {5'd11, 5'd13, 5'd14})));
    c4  = alt ? 4'b0111 : d4_neg(y, k);
    u4  = (3'(c4[0]) + 3'(c4[1]) + 3'(c4[2]) + 3'(c4[3])) != 3'd2;
    flip4 = k || alt || u4 || (y == 3'd3) || (y == 3'd7);
    if (rd6 && flip4) c4 = ~c4;
    rd4 = rd6 ^ u4;
    return {bad, rd4, c6, c4};
  endfunction

  logic                    rd_q;
  logic                    rd_chain;
  logic                    accept;
  logic [11:0]             byte_res;
  logic [10*NUM_BYTES-1:0] enc_d;
  logic [NUM_BYTES-1:0]    kerr_d;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign rd_pos_o   = rd_q;

  // Disparity chain through the beat, byte 0 first
  always_comb begin
    rd_chain = rd_clr_i ? INIT_RD_POS : rd_q;
    enc_d    = '0;
    kerr_d   = '0;
    byte_res = '0;
    for (int n = 0; n < int'(NUM_BYTES); n++) begin
      byte_res            = enc_byte(data_i[8*n +: 8], is_k_i[n], rd_chain);
      enc_d[10*n +: 10]   = byte_res[9:0];
      kerr_d[n]           = byte_res[11];
      rd_chain            = byte_res[10];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      encoded_o   <= '0;
      kerr_o      <= '0;
      rd_q        <= INIT_RD_POS;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      encoded_o   <= enc_d;
      kerr_o      <= kerr_d;
      rd_q        <= rd_chain;
    end else begin
      if (out_ready_i) out_valid_o <= 1'b0;
      if (rd_clr_i)    rd_q        <= INIT_RD_POS;
    end
  end

endmodule

// File: tb/tb_encoder_8b10b_multi.sv
// Directed and randomized bench for encoder_8b10b_multi against a two-column table model.
module tb_encoder_8b10b_multi;

  localparam int unsigned NB   = 2;
  localparam bit          INIT = 1'b0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0, in_ready, rd_clr = 1'b0, out_valid, out_ready = 1'b0, rd_pos;
  logic [8*NB-1:0] data = '0;
  logic [NB-1:0]   is_k = '0, kerr;
  logic [10*NB-1:0] encoded;

  int tests = 0;
  int fails = 0;

  // Model state
  logic            m_valid = 1'b0;
  logic            m_rd    = INIT;
  logic [10*NB-1:0] m_enc  = '0;
  logic [NB-1:0]   m_kerr  = '0;

  logic [5:0] t6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                           6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                           6'b011110, 6'b101011};
  logic [5:0] t6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                           6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                           6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                           6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                           6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                           6'b100001, 6'b010100};
  logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

  encoder_8b10b_multi #(.NUM_BYTES(NB), .INIT_RD_POS(INIT)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data), .is_k_i(is_k), .rd_clr_i(rd_clr), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .encoded_o(encoded), .kerr_o(kerr), .rd_pos_o(rd_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {kerr, rd_after, 10-bit symbol}; RD tracked by counting ones in each subblock
  function automatic logic [11:0] ref_enc(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       bad, rd;
    rd  = rd_in;
    x   = d[4:0];
    y   = d[7:5];
    bad = k && !(x == 5'd28 || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)));
    if (bad) begin x = 5'd28; y = 3'd5; end
    if (k && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
    else                 s6 = rd ? t6p[x] : t6n[x];
    if ($countones(s6) != 3) rd = !rd;
    if (k) s4 = rd ? k4p[y] : k4n[y];
    else if (y == 3'd7 && ((!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (rd && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
      s4 = rd ? 4'b1000 : 4'b0111;
    else s4 = rd ? t4p[y] : t4n[y];
    if ($countones(s4) != 2) rd = !rd;
    return {bad, rd, s6, s4};
  endfunction

  // One clock: drive, check ready, advance model, check registered outputs after the edge
  task automatic step(input logic v, input logic [8*NB-1:0] d, input logic [NB-1:0] k,
                      input logic clr, input logic ordy);
    logic        acc, r;
    logic [11:0] res;
    in_valid = v; data = d; is_k = k; rd_clr = clr; out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    acc = v && (!m_valid || ordy);
    if (acc) begin
      r = clr ? INIT : m_rd;
      for (int n = 0; n < int'(NB); n++) begin
        res = ref_enc(d[8*n +: 8], k[n], r);
        m_enc[10*n +: 10] = res[9:0];
        m_kerr[n] = res[11];
        r = res[10];
      end
      m_valid = 1'b1;
      m_rd = r;
    end else begin
      if (ordy) m_valid = 1'b0;
      if (clr) m_rd = INIT;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("encoded", 32'(encoded), 32'(m_enc));
      chk("kerr", 32'(kerr), 32'(m_kerr));
    end
    chk("rd_pos", 32'(rd_pos), 32'(m_rd));
  endtask

  function automatic logic [7:0] rnd_byte(input logic k);
    if (k && $urandom_range(0, 3) != 0) return legal_k[$urandom_range(0, 11)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [NB-1:0]    rk;
    logic [8*NB-1:0]  rd_data;
    logic [10*NB-1:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_encoded", 32'(encoded), 32'd0);
    chk("rst_kerr", 32'(kerr), 32'd0);
    chk("rst_rd_pos", 32'(rd_pos), 32'(INIT));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // D0.0 pair from RD-: both symbols balanced, RD stays negative
    step(1'b1, 16'h0000, 2'b00, 1'b0, 1'b1);
    chk("d00_syms", 32'(encoded), 32'({10'h274, 10'h274}));
    chk("d00_rd", 32'(rd_pos), 32'd0);

    // K28.5 pair: RD- -> RD+ -> RD-
    step(1'b1, 16'hBCBC, 2'b11, 1'b0, 1'b1);
    chk("k285_syms", 32'(encoded), 32'({10'h305, 10'h0FA}));
    chk("k285_rd", 32'(rd_pos), 32'd0);
    chk("k285_kerr", 32'(kerr), 32'd0);

    // D21.5 is balanced in both subblocks
    step(1'b1, 16'hB5B5, 2'b00, 1'b0, 1'b1);
    chk("d215_syms", 32'(encoded), 32'({10'h2AA, 10'h2AA}));
    chk("d215_rd", 32'(rd_pos), 32'd0);

    // Downstream stall for 5 cycles with new input offered
    step(1'b1, 16'h1234, 2'b00, 1'b0, 1'b1);
    held = encoded;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(i * 16'h1111 + 16'h0F0F), 2'b00, 1'b0, 1'b0);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", 32'(encoded), 32'(held));
    end
    step(1'b1, 16'h5A5A, 2'b00, 1'b0, 1'b1);

    // Illegal K on both bytes: substituted by K28.5, flagged for one beat only
    step(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 2'b00, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 2'b11, 1'b0, 1'b1);
    chk("illk_sym0", 32'(encoded[9:0]), 32'h0FA);
    chk("illk_kerr", 32'(kerr), 32'd3);
    chk("illk_rd", 32'(rd_pos), 32'd0);
    step(1'b1, 16'h0000, 2'b00, 1'b0, 1'b1);
    chk("illk_kerr_clear", 32'(kerr), 32'd0);

    // Reach RD+, then rd_clr on the same cycle as a D0.0 beat
    step(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b1);
    chk("rdpos_set", 32'(rd_pos), 32'd1);
    step(1'b1, 16'h0000, 2'b00, 1'b1, 1'b1);
    chk("rdclr_sym0", 32'(encoded[9:0]), 32'h274);
    chk("rdclr_rd", 32'(rd_pos), 32'd0);

    // Full-rate back-to-back beats
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'($urandom), 2'b00, 1'b0, 1'b1);
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rk = NB'($urandom_range(0, 3) == 0 ? $urandom : 0);
      for (int n = 0; n < int'(NB); n++) rd_data[8*n +: 8] = rnd_byte(rk[n]);
      step($urandom_range(0, 3) != 0, rd_data, rk, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0);
    end

    // Async reset while a beat is held discards it
    step(1'b1, 16'hBC00, 2'b10, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 2'b00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    m_valid = 1'b0; m_rd = INIT; m_enc = '0; m_kerr = '0;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_encoded", 32'(encoded), 32'd0);
    chk("arst_rd", 32'(rd_pos), 32'(INIT));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 2'b00, 1'b0, 1'b1);
    chk("post_rst_sym", 32'(encoded), 32'({10'h274, 10'h274}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
